// File: rtl/acc_reduce_responder_pkg.sv
// Shared constants and types for the accumulator reduce responder.
package acc_reduce_responder_pkg;
    localparam int N_CORE     = 5;
    localparam int N_ACC      = 4;
    localparam int DATA_W     = 32;
    localparam int ACC_IDX_W  = $clog2(N_ACC);
    localparam int CNT_W      = $clog2(N_CORE * 256);

    typedef logic [ACC_IDX_W-1:0] acc_idx_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/acc_reduce_responder_if.sv
// Core-to-parent accumulator request bus. acc_count exists only with ACC_COUNT_EN.
interface acc_reduce_responder_if #(
    parameter int N_CORE = acc_reduce_responder_pkg::N_CORE,
    parameter int N_ACC  = acc_reduce_responder_pkg::N_ACC,
    parameter int DATA_W = acc_reduce_responder_pkg::DATA_W
);
    logic                       acc_req_valid [N_CORE][N_ACC];
    logic [DATA_W-1:0]          acc_data      [N_CORE][N_ACC];
    logic                       acc_req_ready [N_CORE][N_ACC];
    logic                       acc_init_valid;
    logic [$clog2(N_ACC)-1:0]   acc_init_idx;
    logic [DATA_W-1:0]          acc_init_data;
    logic [DATA_W-1:0]          acc_value     [N_ACC];
    logic                       acc_idle;
`ifdef ACC_COUNT_EN
    logic [$clog2(N_CORE*256)-1:0] acc_count  [N_ACC];
`endif

    modport master (
        output acc_req_valid, acc_data, acc_init_valid, acc_init_idx, acc_init_data,
`ifdef ACC_COUNT_EN
        input  acc_count,
`endif
        input  acc_req_ready, acc_value, acc_idle
    );

    modport slave (
        input  acc_req_valid, acc_data, acc_init_valid, acc_init_idx, acc_init_data,
`ifdef ACC_COUNT_EN
        output acc_count,
`endif
        output acc_req_ready, acc_value, acc_idle
    );
endinterface

// File: rtl/acc_reduce_responder_rr_arbiter.sv
// Round-robin arbiter for one accumulator: grants the first requester at or
// after the pointer; block (init of this accumulator) or reset suppress grants.
module acc_reduce_responder_rr_arbiter #(
    parameter int N_REQ = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             block,
    output logic [N_REQ-1:0] gnt
);
    import acc_reduce_responder_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        rr_d  = rr_q;
        found = 1'b0;
        idx   = '0;
        if (!reset && !block) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = PTR_W'((int'(rr_q) + i) % N_REQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    rr_d     = PTR_W'(rr_next(int'(idx), N_REQ));
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end
endmodule

// File: rtl/acc_reduce_responder.sv
// Parent-side responder: per-accumulator round-robin grant, parent-owned sums,
// init loads and idle status. ACC_COUNT_EN adds saturating per-accumulator accept counters.
module acc_reduce_responder #(
    parameter int N_CORE = acc_reduce_responder_pkg::N_CORE,
    parameter int N_ACC  = acc_reduce_responder_pkg::N_ACC,
    parameter int DATA_W = acc_reduce_responder_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    acc_reduce_responder_if.slave  bus
);
    import acc_reduce_responder_pkg::*;

    logic [N_ACC-1:0][N_CORE-1:0] req;
    logic [N_CORE-1:0]            gnt [N_ACC];
    logic [N_ACC-1:0]             init_hit;
    logic [DATA_W-1:0]            acc_value_q [N_ACC];
    logic [DATA_W-1:0]            acc_value_d [N_ACC];
    logic [DATA_W-1:0]            sel;
    logic                         any_valid;
    logic                         any_accept;

`ifdef ACC_COUNT_EN
    localparam int CW = $clog2(N_CORE * 256);
    logic [CW-1:0] acc_count_q [N_ACC];
    logic [CW-1:0] acc_count_d [N_ACC];
`endif

    // Out-of-range init indices never match, so they neither load nor stall.
    always_comb begin
        req      = '0;
        init_hit = '0;
        for (int a = 0; a < N_ACC; a++) begin
            init_hit[a] = bus.acc_init_valid && (int'(bus.acc_init_idx) == a);
            for (int c = 0; c < N_CORE; c++) begin
                req[a][c] = bus.acc_req_valid[c][a];
            end
        end
    end

    for (genvar a = 0; a < N_ACC; a++) begin : g_arb
        acc_reduce_responder_rr_arbiter #(.N_REQ(N_CORE)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req[a]),
            .block (init_hit[a]),
            .gnt   (gnt[a])
        );
    end

    always_comb begin
        any_valid  = 1'b0;
        any_accept = 1'b0;
        sel        = '0;
        for (int a = 0; a < N_ACC; a++) begin
            sel            = '0;
            acc_value_d[a] = acc_value_q[a];
            for (int c = 0; c < N_CORE; c++) begin
                bus.acc_req_ready[c][a] = gnt[a][c];
                any_valid = any_valid | bus.acc_req_valid[c][a];
                sel       = sel | ({DATA_W{gnt[a][c]}} & bus.acc_data[c][a]);
            end
            any_accept = any_accept | (|gnt[a]);
            if (init_hit[a])    acc_value_d[a] = bus.acc_init_data;
            else if (|gnt[a])   acc_value_d[a] = acc_value_q[a] + sel;
`ifdef ACC_COUNT_EN
            acc_count_d[a] = acc_count_q[a];
            if (init_hit[a])                            acc_count_d[a] = '0;
            else if ((|gnt[a]) && (acc_count_q[a] != '1)) acc_count_d[a] = acc_count_q[a] + 1'b1;
`endif
        end
        bus.acc_value = acc_value_q;
        bus.acc_idle  = reset | (!any_valid && !any_accept);
`ifdef ACC_COUNT_EN
        bus.acc_count = acc_count_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < N_ACC; a++) begin
                acc_value_q[a] <= '0;
`ifdef ACC_COUNT_EN
                acc_count_q[a] <= '0;
`endif
            end
        end else begin
            acc_value_q <= acc_value_d;
`ifdef ACC_COUNT_EN
            acc_count_q <= acc_count_d;
`endif
        end
    end
endmodule

// File: tb/tb_acc_reduce_responder.sv
// Directed bench for acc_reduce_responder: vector table plus hand sequences.
module tb_acc_reduce_responder;
    import acc_reduce_responder_pkg::*;

    typedef struct {
        int          acc;
        logic [4:0]  vmask;
        logic [31:0] data;
        logic        init_v;
        acc_idx_t    init_idx;
        logic [31:0] init_data;
        logic [4:0]  exp_rdy;
        logic [31:0] exp_val;
        logic        exp_idle;
    } vec_t;

    vec_t vecs [16];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    acc_reduce_responder_if bus ();

    acc_reduce_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < N_CORE; c++)
            for (int a = 0; a < N_ACC; a++) begin
                bus.acc_req_valid[c][a] = 1'b0;
                bus.acc_data[c][a]      = '0;
            end
        bus.acc_init_valid = 1'b0;
        bus.acc_init_idx   = '0;
        bus.acc_init_data  = '0;
    endtask

    task automatic set_valid(input int a, input logic [4:0] m, input logic [31:0] d);
        for (int c = 0; c < N_CORE; c++) begin
            bus.acc_req_valid[c][a] = m[c];
            bus.acc_data[c][a]      = d;
        end
    endtask

    function automatic logic [4:0] rdy_mask(input int a);
        logic [4:0] m;
        m = '0;
        for (int c = 0; c < N_CORE; c++) m[c] = bus.acc_req_ready[c][a];
        return m;
    endfunction

    function automatic logic other_rdy(input int a);
        logic r;
        r = 1'b0;
        for (int x = 0; x < N_ACC; x++)
            if (x != a)
                for (int c = 0; c < N_CORE; c++) r = r | bus.acc_req_ready[c][x];
        return r;
    endfunction

    int eg [3][4];

    initial begin
        //            acc vmask     data          iv  idx   idata          exp_rdy   exp_val        idle
        vecs[0]  = '{0, 5'b00100, 32'd5,        0, 2'd0, 32'd0,         5'b00100, 32'd5,         1'b0};
        vecs[1]  = '{0, 5'b00000, 32'd0,        0, 2'd0, 32'd0,         5'b00000, 32'd5,         1'b1};
        vecs[2]  = '{0, 5'b00101, 32'd3,        0, 2'd0, 32'd0,         5'b00001, 32'd8,         1'b0};
        vecs[3]  = '{0, 5'b00101, 32'd3,        0, 2'd0, 32'd0,         5'b00100, 32'd11,        1'b0};
        vecs[4]  = '{1, 5'b01011, 32'd1,        0, 2'd0, 32'd0,         5'b00001, 32'd1,         1'b0};
        vecs[5]  = '{1, 5'b01011, 32'd1,        0, 2'd0, 32'd0,         5'b00010, 32'd2,         1'b0};
        vecs[6]  = '{1, 5'b01011, 32'd1,        0, 2'd0, 32'd0,         5'b01000, 32'd3,         1'b0};
        vecs[7]  = '{1, 5'b01011, 32'd1,        0, 2'd0, 32'd0,         5'b00001, 32'd4,         1'b0};
        vecs[8]  = '{1, 5'b01011, 32'd1,        0, 2'd0, 32'd0,         5'b00010, 32'd5,         1'b0};
        vecs[9]  = '{1, 5'b01011, 32'd1,        0, 2'd0, 32'd0,         5'b01000, 32'd6,         1'b0};
        vecs[10] = '{2, 5'b10010, 32'd7,        1, 2'd2, 32'd100,       5'b00000, 32'd100,       1'b0};
        vecs[11] = '{2, 5'b10010, 32'd7,        0, 2'd0, 32'd0,         5'b00010, 32'd107,       1'b0};
        vecs[12] = '{2, 5'b10010, 32'd7,        0, 2'd0, 32'd0,         5'b10000, 32'd114,       1'b0};
        vecs[13] = '{2, 5'b00010, 32'd1,        1, 2'd3, 32'd9,         5'b00010, 32'd115,       1'b0};
        vecs[14] = '{0, 5'b00000, 32'd0,        1, 2'd0, 32'hFFFF_FFFF, 5'b00000, 32'hFFFF_FFFF, 1'b1};
        vecs[15] = '{0, 5'b00001, 32'd2,        0, 2'd0, 32'd0,         5'b00001, 32'd1,         1'b0};

        // Expected grant per accumulator for three all-valid cycles (pointers 1,4,2,0 at start).
        eg = '{'{1, 4, 2, 0}, '{2, 0, 3, 1}, '{3, 1, 4, 2}};

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < N_ACC; a++) begin
            chk("reset_value", 64'(bus.acc_value[a]), 64'd0);
`ifdef ACC_COUNT_EN
            chk("reset_count", 64'(bus.acc_count[a]), 64'd0);
`endif
        end
        chk("reset_idle", 64'(bus.acc_idle), 64'd1);
        bus.acc_req_valid[0][0] = 1'b1;
        #1;
        chk("reset_ready", 64'(rdy_mask(0)), 64'd0);
        clear_inputs();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            clear_inputs();
            set_valid(vecs[i].acc, vecs[i].vmask, vecs[i].data);
            bus.acc_init_valid = vecs[i].init_v;
            bus.acc_init_idx   = vecs[i].init_idx;
            bus.acc_init_data  = vecs[i].init_data;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(rdy_mask(vecs[i].acc)), 64'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_other_ready", i), 64'(other_rdy(vecs[i].acc)), 64'd0);
            chk($sformatf("vec%0d_idle", i), 64'(bus.acc_idle), 64'(vecs[i].exp_idle));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_value", i), 64'(bus.acc_value[vecs[i].acc]), 64'(vecs[i].exp_val));
        end
        chk("hold_value1", 64'(bus.acc_value[1]), 64'd6);
        chk("hold_value2", 64'(bus.acc_value[2]), 64'd115);
        chk("init_other_acc3", 64'(bus.acc_value[3]), 64'd9);

        // Every core valid on every accumulator: one grant per accumulator per cycle.
        clear_inputs();
        for (int a = 0; a < N_ACC; a++) set_valid(a, 5'b11111, 32'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            for (int a = 0; a < N_ACC; a++)
                chk($sformatf("all_valid_c%0d_a%0d", k, a), 64'(rdy_mask(a)), 64'(5'b00001 << eg[k][a]));
            chk("all_valid_idle", 64'(bus.acc_idle), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("all_valid_v0", 64'(bus.acc_value[0]), 64'd4);
        chk("all_valid_v1", 64'(bus.acc_value[1]), 64'd9);
        chk("all_valid_v2", 64'(bus.acc_value[2]), 64'd118);
        chk("all_valid_v3", 64'(bus.acc_value[3]), 64'd12);

        clear_inputs();
        #1;
        chk("drop_idle", 64'(bus.acc_idle), 64'd1);
        for (int a = 0; a < N_ACC; a++) chk("drop_ready", 64'(rdy_mask(a)), 64'd0);

        // Reset mid-stream: no grant applied, pointer restarts from core 0 (acc0 pointer was 4).
        set_valid(0, 5'b11000, 32'd4);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(rdy_mask(0)), 64'd0);
        @(posedge clk);
        #1;
        for (int a = 0; a < N_ACC; a++) chk("midrst_value", 64'(bus.acc_value[a]), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(rdy_mask(0)), 64'(5'b01000));
        @(posedge clk);
        #1;
        chk("post_rst_value", 64'(bus.acc_value[0]), 64'd4);
        clear_inputs();

`ifdef ACC_COUNT_EN
        set_valid(3, 5'b00001, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        clear_inputs();
        chk("count_ten", 64'(bus.acc_count[3]), 64'd10);
        chk("count_value", 64'(bus.acc_value[3]), 64'd10);
        bus.acc_init_valid = 1'b1;
        bus.acc_init_idx   = 2'd3;
        bus.acc_init_data  = 32'd50;
        @(posedge clk);
        #1;
        clear_inputs();
        chk("count_init", 64'(bus.acc_count[3]), 64'd0);
        chk("count_init_value", 64'(bus.acc_value[3]), 64'd50);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_reduce_responder.md
# acc_reduce_responder

Parent-side responder for the per-core accumulator-request handshake. Each core raises `acc_req_valid[c][a]` with `acc_data[c][a]` to contribute a value to accumulator `a`. This block arbitrates among the cores and accepts at most one contribution per accumulator per cycle. It sums accepted values into parent-owned accumulator registers and reports results and idle status to the parent core at the join point.

## Interface
Parameters:
- `N_CORE`, default 5: number of requesting cores, parent included as core 0.
- `N_ACC`, default 4: number of accumulators; same value as the core's accumulator count.
- `DATA_W`, default 32: accumulator and contribution width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `acc_req_valid[N_CORE][N_ACC]`  in  1 each  contribution offered by core c to accumulator a.
- `acc_data[N_CORE][N_ACC]`  in  DATA_W each  contribution value; held stable while valid and not ready.
- `acc_req_ready[N_CORE][N_ACC]`  out  1 each  grant; a transfer occurs when valid && ready.
- `acc_init_valid`  in  1  parent loads an accumulator.
- `acc_init_idx`  in  $clog2(N_ACC)  accumulator to load.
- `acc_init_data`  in  DATA_W  load value.
- `acc_value[N_ACC]`  out  DATA_W each  current accumulator contents, registered.
- `acc_idle`  out  1  high when no request is pending and no accept occurred this cycle.

## Operation
- Each accumulator a has an independent round-robin arbiter over cores 0..N_CORE-1 with pointer `rr[a]`.
- Grant rule: the first core c with valid, searching from `rr[a]` upward with wrap modulo N_CORE, gets `acc_req_ready[c][a]=1`. All other readies for a are 0.
- On grant to core c, `rr[a]` becomes (c+1) mod N_CORE on the next edge. Without a grant, `rr[a]` holds.
- Accept: `acc_value[a] <= acc_value[a] + acc_data[c][a]`. Addition is modulo 2^DATA_W (wrap-around); the carry is discarded.
- Init: if `acc_init_valid` and `acc_init_idx==a`, then `acc_value[a] <= acc_init_data`. In that cycle every ready for a is forced to 0, so init wins and the requests stall. Other accumulators are unaffected.
- An `acc_init_idx` value ≥ N_ACC is ignored: no load and no stall.
- Readies never depend on `acc_req_ready` of other accumulators. A core may hold valid on several accumulators and be granted on all of them in the same cycle.
- `acc_idle` = no `acc_req_valid` asserted anywhere, and no accept this cycle.

## Timing
- Reset values: `acc_value` all 0; `rr` all 0; `acc_req_ready` all 0 in the reset cycle; `acc_idle` 1.
- Ready is combinational from valid, the `rr` pointers and init in the same cycle. A request can be accepted the same cycle valid rises.
- The accepted value is visible on `acc_value` one cycle after the accept edge.
- Throughput: 1 contribution per accumulator per cycle. Aggregate throughput is N_ACC per cycle.
- Worst-case wait for a continuously valid requester is N_CORE-1 cycles (fairness bound).
- If reset is asserted mid-stream, in-flight grants that cycle are not applied. Requesters keep valid asserted and are re-arbitrated from core 0 after reset deasserts.
- Valid deasserting without a transfer is permitted and is not an error.

## Configuration
- `ACC_COUNT_EN`:
  - Defined: adds output `acc_count[N_ACC]`, width $clog2(N_CORE*256), reset 0. It increments by 1 per accept to accumulator a, resets to 0 on init of a, and saturates at its maximum.
  - Undefined: the port and counters are absent, with no other behaviour change.

## Structure
- Shared package: `N_CORE` and `N_ACC` constants (`DATA_W` tied to 32) alongside existing core constants. The accumulator index typedef `acc_idx_t` also belongs there.
- Sub-module: `rr_arbiter` (one `N_CORE`-request round-robin arbiter with its pointer register), instantiated N_ACC times. The top level holds the accumulators, init muxing and idle logic.

## Test plan
- Reset, then core 2 alone valid on acc 0 with data 5 → ready[2][0]=1 same cycle; acc_value[0]=5 next cycle; rr[0]=3.
- Cores 0,1,3 continuously valid on acc 1, data 1 each → grants in order 0,1,3,0,1,3…; acc_value[1] rises by 1 per cycle.
- Init acc 2 with 100 while cores 1 and 4 are valid on acc 2 (data 7) → that cycle has no ready; then grants 1, then 4; acc_value[2] = 100 → 107 → 114.
- acc_value[0]=0xFFFFFFFF; accept data 2 → acc_value[0]=0x00000001.
- All cores valid on all accumulators → every accumulator accepts exactly one per cycle and acc_idle=0. Drop all valids → acc_idle=1 the same cycle.
- `ACC_COUNT_EN`: 10 accepts on acc 3, then init → acc_count[3] reads 10, then 0. Also assert reset mid-stream → all outputs return to reset values the next cycle.
